// File: rtl/iob2axil_fsm.sv
// Native valid/ready slave to AXI4-Lite master bridge with per-request registered payload.
// Optional transaction timeout is compiled in with `define AXIL_TIMEOUT_EN.
module iob2axil_fsm #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [2:0]  AXI_PROT  = 3'b010,
  parameter int          TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // native slave side
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [1:0]          resp,
  // AXI4-Lite write address channel
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  // AXI4-Lite write data channel
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  // AXI4-Lite read data channel
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  // FSM state for observation
  output logic [2:0]          dbg_state
);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_W < 1 || ADDR_W < 1) begin : g_bad_param
    $error("iob2axil_fsm: DATA_W must be 32 or 64, TIMEOUT_W and ADDR_W at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done;
  logic                w_done;
  logic                to_hit;
  logic                aw_hs;
  logic                w_hs;

  // Handshake rule on every AXI channel: a transfer happens in the cycle where
  // valid and ready are both high; valid never waits for ready and holds until then.
  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid & m_axil_wready;

`ifdef AXIL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state != S_DONE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Abandons whatever handshake is pending; the slave needs a reset afterwards.
  assign to_hit = (state != S_IDLE) && (state != S_DONE) && (&tmo_cnt);
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (valid) begin
          state_nxt = (|wstrb) ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if (to_hit) begin
          state_nxt = S_DONE;
        end else if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (to_hit || m_axil_bvalid) begin
          state_nxt = S_DONE;
        end
      end
      S_RADDR: begin
        if (to_hit) begin
          state_nxt = S_DONE;
        end else if (m_axil_arready) begin
          state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (to_hit || m_axil_rvalid) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    ready          = 1'b0;
    case (state)
      S_WADDR: begin
        m_axil_awvalid = ~aw_done & ~to_hit;
        m_axil_wvalid  = ~w_done & ~to_hit;
      end
      S_WRESP: m_axil_bready  = ~to_hit;
      S_RADDR: m_axil_arvalid = ~to_hit;
      S_RDATA: m_axil_rready  = ~to_hit;
      S_DONE:  ready          = 1'b1;
      default: ;
    endcase
  end

  // Request payload is captured once in IDLE so the AXI side never sees native-side churn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == S_IDLE && valid) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if ((state == S_WRESP && m_axil_bvalid) || state == S_DONE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == S_WADDR) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      resp  <= 2'b00;
    end else if (to_hit) begin
      rdata <= '0;
      resp  <= 2'b11;
    end else if (state == S_RDATA && m_axil_rvalid) begin
      rdata <= m_axil_rdata;
      resp  <= m_axil_rresp;
    end else if (state == S_WRESP && m_axil_bvalid) begin
      resp  <= m_axil_bresp;
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_awprot = AXI_PROT;
  assign m_axil_arprot = AXI_PROT;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_iob2axil_fsm.sv
// Directed bench for iob2axil_fsm: zero-wait write/read, split AW/W, error response,
// back-to-back request, asynchronous reset and (with AXIL_TIMEOUT_EN) timeout.
module tb_iob2axil_fsm;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SB_W   = DATA_W + 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WADDR = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic                clk;
  logic                rst_n;
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic [1:0]          resp;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [2:0]          dbg_state;

  int errors = 0;
  int checks = 0;
  // entry: {is_read, resp, rdata}
  logic [SB_W-1:0] exp_q[$];

  iob2axil_fsm #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_PROT(3'b010), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .resp(resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W/8-1:0] s);
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic sb_push(input logic is_rd, input logic [1:0] r, input logic [DATA_W-1:0] d);
    exp_q.push_back({is_rd, r, d});
  endtask

  // Scoreboard: called in the cycle ready is expected high
  task automatic sb_complete(input string tag);
    logic [SB_W-1:0] e;
    chk({tag, "_ready"}, ready, 1'b1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_resp"}, resp, e[DATA_W+1:DATA_W]);
      if (e[DATA_W+2]) chk({tag, "_rdata"}, rdata, e[DATA_W-1:0]);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; m_rdata = '0; rresp = 2'b00; rvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, ready}, 6'b0);
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_rdata", rdata, 0);
    chk("reset_resp", resp, 2'b00);
    rst_n = 1'b1;
    tick();

    // Zero-wait write
    drive_req(32'h10, 32'hDEADBEEF, 4'hF);
    awready = 1'b1; wready = 1'b1;
    sb_push(1'b0, 2'b00, '0);
    chk("wr_c0_idle", dbg_state, ST_IDLE);
    tick();
    chk("wr_c1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    chk("wr_c1_awaddr", awaddr, 32'h10);
    chk("wr_c1_wdata", m_wdata, 32'hDEADBEEF);
    chk("wr_c1_wstrb", m_wstrb, 4'hF);
    chk("wr_c1_awprot", awprot, 3'b010);
    chk("wr_c1_no_ready", ready, 1'b0);
    tick();
    bvalid = 1'b1; bresp = 2'b00;
    chk("wr_c2_bready", bready, 1'b1);
    chk("wr_c2_valids_low", {awvalid, wvalid}, 2'b00);
    tick();
    bvalid = 1'b0;
    sb_complete("wr_c3");
    valid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    chk("wr_c4_ready_low", ready, 1'b0);
    chk("wr_c4_idle", dbg_state, ST_IDLE);

    // Zero-wait read
    drive_req(32'h20, 32'h0, 4'h0);
    arready = 1'b1;
    sb_push(1'b1, 2'b00, 32'h12345678);
    tick();
    chk("rd_c1_arvalid", arvalid, 1'b1);
    chk("rd_c1_araddr", araddr, 32'h20);
    chk("rd_c1_arprot", arprot, 3'b010);
    chk("rd_c1_no_aw", awvalid, 1'b0);
    tick();
    arready = 1'b0;
    rvalid = 1'b1; m_rdata = 32'h12345678; rresp = 2'b00;
    chk("rd_c2_rready", rready, 1'b1);
    chk("rd_c2_arvalid_low", arvalid, 1'b0);
    tick();
    rvalid = 1'b0; m_rdata = '0;
    sb_complete("rd_c3");
    valid = 1'b0;
    tick();
    chk("rd_ready_one_cycle", ready, 1'b0);
    chk("rd_rdata_hold", rdata, 32'h12345678);

    // Split acceptance: W accepted three cycles before AW
    drive_req(32'h30, 32'hA5A5A5A5, 4'h3);
    sb_push(1'b0, 2'b01, '0);
    tick();
    chk("sp_c1_both_valid", {awvalid, wvalid}, 2'b11);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    addr = 32'hFFF0; wdata = 32'h0; wstrb = 4'hF;
    chk("sp_c2_w_dropped", {awvalid, wvalid}, 2'b10);
    chk("sp_c2_awaddr", awaddr, 32'h30);
    tick();
    chk("sp_c3_aw_waiting", {awvalid, wvalid}, 2'b10);
    chk("sp_c3_awaddr", awaddr, 32'h30);
    chk("sp_c3_wdata", m_wdata, 32'hA5A5A5A5);
    tick();
    awready = 1'b1;
    chk("sp_c4_awvalid", awvalid, 1'b1);
    chk("sp_c4_awaddr", awaddr, 32'h30);
    chk("sp_c4_state", dbg_state, ST_WADDR);
    tick();
    awready = 1'b0;
    bvalid = 1'b1; bresp = 2'b01;
    chk("sp_c5_state", dbg_state, ST_WRESP);
    chk("sp_c5_bready", bready, 1'b1);
    chk("sp_c5_awvalid_low", awvalid, 1'b0);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk("sp_c6_state", dbg_state, ST_DONE);
    sb_complete("sp_c6");
    valid = 1'b0;
    tick();

    // Error read, then a write requested back-to-back in the ready cycle
    drive_req(32'h40, 32'h0, 4'h0);
    arready = 1'b1;
    sb_push(1'b1, 2'b10, 32'hBAD0BAD0);
    tick();
    chk("er_c1_arvalid", arvalid, 1'b1);
    tick();
    arready = 1'b0;
    rvalid = 1'b1; m_rdata = 32'hBAD0BAD0; rresp = 2'b10;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    sb_complete("er_c3");
    drive_req(32'h50, 32'h01020304, 4'h1);
    awready = 1'b1; wready = 1'b1;
    sb_push(1'b0, 2'b00, '0);
    tick();
    chk("b2b_idle", dbg_state, ST_IDLE);
    chk("b2b_ready_low", ready, 1'b0);
    tick();
    chk("b2b_aw_w_valid", {awvalid, wvalid}, 2'b11);
    chk("b2b_awaddr", awaddr, 32'h50);
    chk("b2b_wstrb", m_wstrb, 4'h1);
    tick();
    bvalid = 1'b1; bresp = 2'b00;
    chk("b2b_bready", bready, 1'b1);
    tick();
    bvalid = 1'b0;
    sb_complete("b2b_done");
    valid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();

    // Asynchronous reset while waiting in RDATA
    drive_req(32'h60, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    tick();
    arready = 1'b0;
    chk("rst_rready_before", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_low", {arvalid, rready, ready, awvalid, wvalid, bready}, 6'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", resp, 2'b00);
    valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_after_idle", dbg_state, ST_IDLE);
    chk("rst_after_arvalid", arvalid, 1'b0);

`ifdef AXIL_TIMEOUT_EN
    // Slave never accepts AW/W: counter saturates at 15 and forces completion
    drive_req(32'h70, 32'hCAFEF00D, 4'hF);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_ready", ready, 1'b1);
    chk("tmo_latency", n, 17);
    chk("tmo_resp", resp, 2'b11);
    chk("tmo_rdata", rdata, 0);
    chk("tmo_valids_low", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    valid = 1'b0;
    tick();
    chk("tmo_ready_low", ready, 1'b0);
    chk("tmo_idle", dbg_state, ST_IDLE);
`else
    n = 0;
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
